// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for a shared 2**SIZE:1 mux.
// One requester is picked per transfer. Its word is registered and offered
// downstream on a valid/ready interface.
//
// Handshake: a word moves downstream on any posedge where out_valid=1 and
// out_ready=1. A requester's word is taken on any posedge where its gnt bit
// is 1. gnt is combinational from req, ptr, state, out_ready and reset.
module rr_mux_arbiter #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH*(2**SIZE)-1:0] in,
    input  logic [(2**SIZE)-1:0]       req,
    output logic [(2**SIZE)-1:0]       gnt,
    output logic [WIDTH-1:0]           out_data,
    output logic [SIZE-1:0]            out_sel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       dbg_state_o,
    output logic [SIZE-1:0]            dbg_ptr_o
);

    localparam int N = 2 ** SIZE;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SIZE-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [SIZE-1:0]   sel_q, sel_d;

    logic              can_take;
    logic              found;
    logic              gnt_any;
    logic [SIZE-1:0]   winner;
    logic [SIZE-1:0]   idx;
    logic [WIDTH-1:0]  word_sel;

    // The output register can take a new word when it is empty or being drained.
    assign can_take = (state_q == IDLE) || out_ready;

    // Scan requesters starting at ptr and wrapping; the first active one wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr_q + SIZE'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // One-hot grant, suppressed while stalled or in reset.
    always_comb begin
        gnt_any = found && can_take && !reset;
        gnt     = '0;
        if (gnt_any) begin
            gnt[winner] = 1'b1;
        end
    end

    // Mux select: route the winning requester's slice.
    always_comb begin
        word_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (winner == SIZE'(i)) begin
                word_sel = in[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state: load on grant, empty when drained without a replacement.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        if (gnt_any) begin
            state_d = FULL;
            data_d  = word_sel;
            sel_d   = winner;
            ptr_d   = winner + SIZE'(1);
        end else if ((state_q == FULL) && out_ready) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign out_valid   = (state_q == FULL);
    assign out_data    = data_q;
    assign out_sel     = sel_q;
    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter with WIDTH=3, SIZE=3.
// Word i on the input bus is (i mod 4).
module tb_rr_mux_arbiter;

  localparam int W  = 3;
  localparam int S  = 3;
  localparam int N  = 8;

  logic           clk;
  logic           reset;
  logic [W*N-1:0] in_bus;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [W-1:0]   out_data;
  logic [S-1:0]   out_sel;
  logic           out_valid;
  logic           out_ready;
  logic           dbg_state;
  logic [S-1:0]   dbg_ptr;

  int checks = 0;
  int errors = 0;

  // Expected {out_sel, out_data} in delivery order.
  logic [S+W-1:0] exp_q[$];

  rr_mux_arbiter #(.WIDTH(W), .SIZE(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in_bus),
    .req         (req),
    .gnt         (gnt),
    .out_data    (out_data),
    .out_sel     (out_sel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dbg_state_o (dbg_state),
    .dbg_ptr_o   (dbg_ptr)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < N; i++) in_bus[i*W +: W] = W'(i % 4);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [S+W-1:0] exp_word(input int idx);
    logic [S-1:0] s;
    logic [W-1:0] d;
    s = S'(idx);
    d = W'(idx % 4);
    return {s, d};
  endfunction

  // Driver: apply req/out_ready 2 time units after posedge, check gnt at +3,
  // and queue the word the grant should deliver.
  task automatic drive(input logic [N-1:0] r, input logic rdy, input logic [N-1:0] exp_gnt);
    @(posedge clk);
    #2;
    req       = r;
    out_ready = rdy;
    #1;
    check("gnt", int'(gnt), int'(exp_gnt));
    for (int i = 0; i < N; i++) begin
      if (exp_gnt[i]) exp_q.push_back(exp_word(i));
    end
  endtask

  // Monitor: on each accepted output beat, compare against the queue head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_word: got sel=%0d data=%0d, expected nothing", out_sel, out_data);
      end else begin
        logic [S+W-1:0] e;
        e = exp_q.pop_front();
        check("out_word", int'({out_sel, out_data}), int'(e));
      end
    end
  end

  initial begin
    reset     = 1'b1;
    req       = '0;
    out_ready = 1'b0;

    // 1. Reset two cycles with req=0.
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #3;
      check("rst_valid", int'(out_valid), 0);
      check("rst_data", int'(out_data), 0);
      check("rst_sel", int'(out_sel), 0);
      check("rst_gnt", int'(gnt), 0);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;

    // 2. Single requester 3.
    drive(8'h08, 1'b1, 8'h08);
    drive(8'h00, 1'b1, 8'h00);
    check("t2_ptr", int'(dbg_ptr), 4);

    // Brief reset so the sweep starts from ptr=0.
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("pre3_ptr", int'(dbg_ptr), 0);

    // 3. All requesting: winners 0..7 then 0.
    for (int k = 0; k < 9; k++) begin
      drive(8'hFF, 1'b1, N'(1) << (k % 8));
    end

    // 4. Stall with out_valid=1 and req=01 for 3 cycles.
    for (int k = 0; k < 3; k++) begin
      drive(8'h01, 1'b0, 8'h00);
      check("stall_valid", int'(out_valid), 1);
      check("stall_sel", int'(out_sel), 0);
      check("stall_data", int'(out_data), 0);
    end
    check("stall_ptr", int'(dbg_ptr), 1);
    drive(8'h01, 1'b1, 8'h01);

    // 5. ptr=6 after grant to 5; req 5+0 picks 0, then 5 alone.
    drive(8'h20, 1'b1, 8'h20);
    drive(8'h21, 1'b1, 8'h01);
    drive(8'h20, 1'b1, 8'h20);

    // 6. Reset while full and all requesting.
    @(posedge clk);
    #2;
    reset     = 1'b1;
    req       = 8'hFF;
    out_ready = 1'b1;
    #1;
    check("rst6_gnt", int'(gnt), 0);
    check("rst6_valid_before", int'(out_valid), 1);
    exp_q.delete();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst6_valid", int'(out_valid), 0);
    check("rst6_ptr", int'(dbg_ptr), 0);
    check("rst6_gnt_first", int'(gnt), 8'h01);
    exp_q.push_back(exp_word(0));

    // Drain remaining words.
    drive(8'h00, 1'b1, 8'h00);
    drive(8'h00, 1'b1, 8'h00);
    @(posedge clk);
    #3;
    check("drain_valid", int'(out_valid), 0);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
